// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op-select codes and
// signed saturation limits.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Widest operand the saturation helper can describe
   localparam int unsigned SAT_MAX_W = 64;

   // Signed max (0111..1) or min (1000..0) of width w, right-aligned
   function automatic logic [SAT_MAX_W-1:0] signed_limit(input int unsigned w,
                                                         input logic        neg);
      logic [SAT_MAX_W-1:0] msb;
      msb = SAT_MAX_W'(1) << (w - 1);
      return neg ? msb : (msb - SAT_MAX_W'(1));
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, payload} slot of the result pipeline; holds while the pipe stalls.
module pipe_stage #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_advance,
   input  logic         i_valid,
   input  logic [W-1:0] i_payload,
   output logic         o_valid,
   output logic [W-1:0] o_payload
);

   logic         r_valid;
   logic [W-1:0] r_payload;

   // Slot register: load on advance, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_payload <= '0;
      end else if (i_advance) begin
         r_valid   <= i_valid;
         r_payload <= i_payload;
      end
   end

   assign o_valid   = r_valid;
   assign o_payload = r_payload;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor with carry/borrow-in, carry and overflow
// flags, STAGES cycles of latency and a whole-pipe valid/ready stall.
// Optional macro SATURATE_EN: clamp q to signed max/min on overflow.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sel,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] q,
   output logic         c_out,
   output logic         ovf,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int unsigned SW = N + 1;   // sum width including carry
   localparam int unsigned PW = N + 2;   // payload {ovf, c_out, q}

   logic [N-1:0]               w_b_eff;
   logic                       w_cin_eff;
   logic [SW-1:0]              w_sum;
   logic                       w_ovf;
   logic [N-1:0]               w_q;
   logic [PW-1:0]              w_pay_s1;
   logic                       w_advance;
   logic [STAGES-1:0]          w_valid;
   logic [STAGES-1:0][PW-1:0]  w_pay;

   // Stage-1 arithmetic: subtraction as a + ~b + ~c_in at full width
   always_comb begin
      w_b_eff   = (sel == OP_SUB) ? ~b : b;
      w_cin_eff = (sel == OP_SUB) ? ~c_in : c_in;
      w_sum     = {1'b0, a} + {1'b0, w_b_eff} + SW'(w_cin_eff);
      w_ovf     = (a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != a[N-1]);
`ifdef SATURATE_EN
      w_q       = w_ovf ? N'(signed_limit(N, a[N-1])) : w_sum[N-1:0];
`else
      w_q       = w_sum[N-1:0];
`endif
      w_pay_s1  = {w_ovf, w_sum[N], w_q};
   end

   // Whole pipe moves when the output slot is empty or being taken
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   // Stage chain: first slot takes the arithmetic result, the rest are delays
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         pipe_stage #(.W(PW)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_advance (w_advance),
            .i_valid   (in_valid),
            .i_payload (w_pay_s1),
            .o_valid   (w_valid[g]),
            .o_payload (w_pay[g])
         );
      end else begin : g_rest
         pipe_stage #(.W(PW)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_advance (w_advance),
            .i_valid   (w_valid[g-1]),
            .i_payload (w_pay[g-1]),
            .o_valid   (w_valid[g]),
            .o_payload (w_pay[g])
         );
      end
   end

   assign out_valid         = w_valid[STAGES-1];
   assign {ovf, c_out, q}   = w_pay[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vectors on an N=8/STAGES=2 instance plus
// randomised streams on N=16/STAGES=4 and N=8/STAGES=1 instances, all checked
// against an integer-arithmetic reference model. Honours SATURATE_EN.
`timescale 1ns/1ps
module tb_addsub_pipe;

   localparam int unsigned N  = 8;
   localparam int unsigned ST = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] a, b, q;
   logic         c_in, sel, in_valid, in_ready, c_out, ovf, out_valid, out_ready;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   addsub_pipe #(.N(N), .STAGES(ST)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .sel(sel),
      .in_valid(in_valid), .in_ready(in_ready), .q(q), .c_out(c_out),
      .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
   );

   typedef struct {
      logic [31:0] q;
      logic        c;
      logic        v;
      int          tag;
   } exp_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: ideal signed/unsigned integer results, then wrap or clamp
   function automatic exp_t ref_op(input int w, input logic [31:0] ra, input logic [31:0] rb,
                                   input logic rc, input logic rs);
      exp_t   r;
      longint modv, half, ua, ub, ci, sa, sb, ures, sres;
      modv = longint'(1) << w;
      half = modv / 2;
      ua   = longint'(ra);
      ub   = longint'(rb);
      ci   = rc ? 1 : 0;
      sa   = (ua >= half) ? ua - modv : ua;
      sb   = (ub >= half) ? ub - modv : ub;
      if (!rs) begin
         ures = ua + ub + ci;
         sres = sa + sb + ci;
         r.c  = (ures >= modv);
      end else begin
         ures = ua - ub - ci;
         sres = sa - sb - ci;
         r.c  = (ures >= 0);
      end
      r.q   = 32'(((ures % modv) + modv) % modv);
      r.v   = (sres > half - 1) || (sres < -half);
`ifdef SATURATE_EN
      if (r.v) r.q = (sres > 0) ? 32'(half - 1) : 32'(half);
`endif
      r.tag = 0;
      return r;
   endfunction

   // Monitor for the main instance: ordering, values, latency, stall rules
   exp_t         exp_q[$];
   int           adv_cnt  = 0;
   int           n_pop    = 0;
   logic         stall_prev = 1'b0;
   logic [N-1:0] q_prev;
   logic         c_prev, v_prev, ov_prev;

   always @(negedge clk) begin
      exp_t e;
      logic adv;
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         adv = !out_valid || out_ready;
         check("in_ready_rule", 32'(in_ready), 32'(adv));
         if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 32'(ov_prev));
            check("hold_q",     32'(q),         32'(q_prev));
            check("hold_cout",  32'(c_out),     32'(c_prev));
            check("hold_ovf",   32'(ovf),       32'(v_prev));
         end
         if (out_valid && out_ready) begin
            check("pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("q",       32'(q),             e.q);
               check("c_out",   32'(c_out),         32'(e.c));
               check("ovf",     32'(ovf),           32'(e.v));
               check("latency", 32'(adv_cnt - e.tag), 32'(ST));
               n_pop++;
            end
         end
         if (in_valid && adv) begin
            e     = ref_op(N, 32'(a), 32'(b), c_in, sel);
            e.tag = adv_cnt;
            exp_q.push_back(e);
         end
         if (adv) adv_cnt++;
         stall_prev = out_valid && !out_ready;
         q_prev  = q;
         c_prev  = c_out;
         v_prev  = ovf;
         ov_prev = out_valid;
      end
   end

   // Sweep instances: random operands, random backpressure, same model
   for (genvar g = 0; g < 2; g++) begin : sw
      localparam int unsigned SN = (g == 0) ? 16 : 8;
      localparam int unsigned SS = (g == 0) ? 4 : 1;

      logic [SN-1:0] sa, sb, sq;
      logic          srst, sc, ss, siv, sir, sco, sov, sovld, sor;
      logic          done = 1'b0;
      exp_t          sexp[$];
      int            sadv = 0;

      addsub_pipe #(.N(SN), .STAGES(SS)) u_dut (
         .clk(clk), .rst(srst), .a(sa), .b(sb), .c_in(sc), .sel(ss),
         .in_valid(siv), .in_ready(sir), .q(sq), .c_out(sco),
         .ovf(sov), .out_valid(sovld), .out_ready(sor)
      );

      initial begin
         srst = 1'b1; sa = '0; sb = '0; sc = 1'b0; ss = 1'b0; siv = 1'b0; sor = 1'b1;
         repeat (3) @(posedge clk);
         #1 srst = 1'b0;
         for (int i = 0; i < 300; i++) begin
            sa  = SN'($urandom);
            sb  = SN'($urandom);
            sc  = 1'($urandom);
            ss  = 1'($urandom);
            siv = ($urandom_range(0, 3) != 0);
            sor = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
         end
         siv = 1'b0;
         sor = 1'b1;
         repeat (SS + 3) @(posedge clk);
         #1;
         check($sformatf("sw%0d_drained", g), 32'(sexp.size()), 32'(0));
         done = 1'b1;
      end

      always @(negedge clk) begin
         exp_t e;
         if (srst) begin
            sexp.delete();
         end else begin
            if (sovld && sor) begin
               check($sformatf("sw%0d_pending", g), 32'(sexp.size() != 0), 32'(1));
               if (sexp.size() != 0) begin
                  e = sexp.pop_front();
                  check($sformatf("sw%0d_q", g),       32'(sq),          e.q);
                  check($sformatf("sw%0d_c_out", g),   32'(sco),         32'(e.c));
                  check($sformatf("sw%0d_ovf", g),     32'(sov),         32'(e.v));
                  check($sformatf("sw%0d_latency", g), 32'(sadv - e.tag), 32'(SS));
               end
            end
            if (siv && (!sovld || sor)) begin
               e     = ref_op(SN, 32'(sa), 32'(sb), sc, ss);
               e.tag = sadv;
               sexp.push_back(e);
            end
            if (!sovld || sor) sadv++;
         end
      end
   end

`ifdef SATURATE_EN
   localparam logic [7:0] E_ADD_OVF = 8'h7F;
   localparam logic [7:0] E_SUB_OVF = 8'h80;
`else
   localparam logic [7:0] E_ADD_OVF = 8'h80;
   localparam logic [7:0] E_SUB_OVF = 8'h7F;
`endif

   // Single op into an empty pipe; checks exact latency and literal result
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input logic [7:0] eq, input logic ec,
                        input logic ev, input string nm);
      a = ta; b = tb; c_in = tc; sel = ts; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (ST - 1) begin
         check({nm, "_early"}, 32'(out_valid), 32'(0));
         @(posedge clk);
         #1;
      end
      check({nm, "_valid"}, 32'(out_valid), 32'(1));
      check({nm, "_q"},     32'(q),         32'(eq));
      check({nm, "_cout"},  32'(c_out),     32'(ec));
      check({nm, "_ovf"},   32'(ovf),       32'(ev));
      @(posedge clk);
      #1;
   endtask

   // Present an op and hold it until the handshake completes
   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts);
      logic acc;
      int   guard;
      guard = 0;
      a = ta; b = tb; c_in = tc; sel = ts; in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 50);
      if (!acc) check("send_timeout", 32'(acc), 32'(1));
   endtask

   initial begin
      int pops_before;
      int t;
      logic [7:0] q_stall;

      rst = 1'b1; a = '0; b = '0; c_in = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", 32'(out_valid), 32'(0));
      check("reset_q",     32'(q),         32'(0));
      check("reset_cout",  32'(c_out),     32'(0));
      check("reset_ovf",   32'(ovf),       32'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_exit_ready", 32'(in_ready), 32'(1));

      // Directed arithmetic with hand-computed results
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, E_ADD_OVF, 1'b0, 1'b1, "add_7f_01");
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00,     1'b1, 1'b0, "add_ff_01");
      do_op(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11,     1'b0, 1'b0, "add_cin");
      do_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE,     1'b0, 1'b0, "sub_05_07");
      do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFD,     1'b0, 1'b0, "sub_05_07_b");
      do_op(8'h80, 8'h01, 1'b0, 1'b1, E_SUB_OVF, 1'b1, 1'b1, "sub_80_01");
      do_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h00,     1'b1, 1'b0, "sub_zero");

      // Reset with two ops in flight
      a = 8'h11; b = 8'h22; c_in = 1'b0; sel = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 a = 8'h33; b = 8'h01;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("rst_inflight", 32'(out_valid), 32'(1));
      #3 rst = 1'b1;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'(0));
      check("rst_mid_q",     32'(q),         32'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("rst_no_ghost", 32'(out_valid), 32'(0));
      end

      // Backpressure: four ops, output blocked for three cycles
      pops_before = n_pop;
      fork
         begin
            send(8'h10, 8'h01, 1'b0, 1'b0);
            send(8'h20, 8'h02, 1'b0, 1'b1);
            send(8'h7F, 8'h7F, 1'b0, 1'b0);
            send(8'h80, 8'h7F, 1'b1, 1'b1);
            in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            q_stall = q;
            check("bp_in_ready", 32'(in_ready), 32'(0));
            repeat (2) begin
               @(negedge clk);
               check("bp_in_ready", 32'(in_ready), 32'(0));
               check("bp_q_stable", 32'(q),        32'(q_stall));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (ST + 3) @(posedge clk);
      #1;
      check("bp_count",   32'(n_pop - pops_before), 32'(4));
      check("bp_drained", 32'(exp_q.size()),        32'(0));

      // Random stream with random backpressure on the main instance
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); sel = 1'($urandom);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (ST + 3) @(posedge clk);
      #1;
      check("rand_drained", 32'(exp_q.size()), 32'(0));

      t = 0;
      while (!(sw[0].done && sw[1].done) && t < 5000) begin
         @(posedge clk);
         t++;
      end
      check("sweep_done", 32'(sw[0].done && sw[1].done), 32'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
